// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: next-PC operation codes, memory map defaults
// and the branch-offset helper used by the fetch stage.
package mips_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_t;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEFAULT = 4096;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  // Word offset of a 16-bit branch immediate, sign-extended to a byte offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/f_d_reg.sv
// F/D pipeline register: holds on stall, loads a bubble on flush,
// otherwise captures the fetched PC/instruction as a valid entry.
module f_d_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= PC_RESET;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      // A flushed slot still tracks the fetch PC so the bubble has a sane address.
      r_pc <= i_pc;
      if (i_flush) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else begin
        r_instr <= i_instr;
        r_valid <= 1'b1;
      end
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/f_fetch_npc.sv
// Fetch stage: PC register, next-PC selection and F/D register.
// NPC_DELAY_SLOT_EN selects architectural delay-slot behaviour (no flush, link = pc+8).
module f_fetch_npc
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter int unsigned IM_WORDS = IM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [31:0] F_instr,
  input  logic        D_cmp_sig,
  input  logic [1:0]  D_npc_op,
  input  logic [31:0] D_rs_val,
  output logic [31:0] F_pc,
  output logic        F_pc_err,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_link,
  output logic        D_valid
);

  // One bit wider so the end address cannot wrap for maps near the top of memory.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + ({1'b0, 32'(IM_WORDS)} << 2);

`ifdef NPC_DELAY_SLOT_EN
  localparam logic [31:0] LINK_OFS = 32'd8;
`else
  localparam logic [31:0] LINK_OFS = 32'd4;
`endif

  logic [31:0] r_pc;
  logic [31:0] w_seq_pc;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_npc;
  logic        w_redirect;
  logic        w_flush;
  npc_op_t     w_op;

  assign w_op        = npc_op_t'(D_npc_op);
  assign w_seq_pc    = r_pc + 32'd4;
  assign w_br_target = D_pc + 32'd4 + br_offset(D_instr[15:0]);
  assign w_j_target  = {D_pc[31:28], D_instr[25:0], 2'b00};

  always_comb begin
    w_redirect = 1'b0;
    w_npc      = w_seq_pc;
    if (D_valid) begin
      case (w_op)
        NPC_BR: begin
          if (D_cmp_sig) begin
            w_redirect = 1'b1;
            w_npc      = w_br_target;
          end
        end
        NPC_J: begin
          w_redirect = 1'b1;
          w_npc      = w_j_target;
        end
        NPC_JR: begin
          w_redirect = 1'b1;
          w_npc      = D_rs_val;
        end
        default: ;
      endcase
    end
  end

`ifdef NPC_DELAY_SLOT_EN
  assign w_flush = 1'b0;
`else
  assign w_flush = w_redirect;
`endif

  // Stall freezes the PC, so a pending redirect is simply re-evaluated next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= PC_RESET;
    end else if (!stall) begin
      r_pc <= w_npc;
    end
  end

  f_d_reg #(
    .PC_RESET (PC_RESET)
  ) u_f_d_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_hold  (stall),
    .i_flush (w_flush),
    .i_pc    (r_pc),
    .i_instr (F_instr),
    .o_pc    (D_pc),
    .o_instr (D_instr),
    .o_valid (D_valid)
  );

  assign F_pc     = r_pc;
  assign D_link   = D_pc + LINK_OFS;
  assign F_pc_err = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || ({1'b0, r_pc} >= IM_END);

endmodule

// File: tb/tb_f_fetch_npc.sv
// Self-checking bench for f_fetch_npc; honours NPC_DELAY_SLOT_EN when defined.
module tb_f_fetch_npc;

  localparam logic [31:0] BASE = 32'h0000_3000;
`ifdef NPC_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  localparam logic [31:0] LINK_OFS = DS ? 32'd8 : 32'd4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] F_instr;
  logic        D_cmp_sig = 1'b0;
  logic [1:0]  D_npc_op = 2'd0;
  logic [31:0] D_rs_val = 32'h0;
  logic [31:0] F_pc;
  logic        F_pc_err;
  logic [31:0] D_pc;
  logic [31:0] D_instr;
  logic [31:0] D_link;
  logic        D_valid;

  f_fetch_npc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .F_instr   (F_instr),
    .D_cmp_sig (D_cmp_sig),
    .D_npc_op  (D_npc_op),
    .D_rs_val  (D_rs_val),
    .F_pc      (F_pc),
    .F_pc_err  (F_pc_err),
    .D_pc      (D_pc),
    .D_instr   (D_instr),
    .D_link    (D_link),
    .D_valid   (D_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word 0 is jal 0x0000C10, word 1 is beq imm16=3.
  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [31:0] idx;
    if (a[1:0] != 2'b00 || a < BASE || a >= BASE + 32'h4000) return 32'h0;
    idx = (a - BASE) >> 2;
    if (idx == 0) return 32'h0C00_0C10;
    if (idx == 1) return 32'h1000_0003;
    return 32'h2400_0000 | idx;
  endfunction

  always_comb F_instr = imem(F_pc);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        cmp;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic [31:0] di;
    logic        v;
    logic        err;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic [31:0] di;
    logic [31:0] link;
    logic        v;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic rst, input logic st, input logic cmp,
                              input logic [1:0] op, input logic [31:0] rs,
                              input logic [31:0] fpc, input logic [31:0] dpc,
                              input logic [31:0] di, input logic v, input logic err);
    vec_t r;
    r.rst = rst; r.stall = st; r.cmp = cmp; r.op = op; r.rs = rs;
    r.fpc = fpc; r.dpc = dpc; r.di = di; r.v = v; r.err = err;
    return r;
  endfunction

  function automatic vec_t rst_vec();
    return mk(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, BASE, BASE, 32'h0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d: got %h required %h", name, id, act, req);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue required an entry");
      return;
    end
    e = sb.pop_front();
    $display("vec %0d: F_pc=%h err=%0b D_pc=%h D_instr=%h D_valid=%0b D_link=%h",
             e.id, F_pc, F_pc_err, D_pc, D_instr, D_valid, D_link);
    chk("F_pc", e.id, F_pc, e.fpc);
    chk("F_pc_err", e.id, {31'b0, F_pc_err}, {31'b0, e.err});
    chk("D_pc", e.id, D_pc, e.dpc);
    chk("D_instr", e.id, D_instr, e.di);
    chk("D_valid", e.id, {31'b0, D_valid}, {31'b0, e.v});
    chk("D_link", e.id, D_link, e.link);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    stall     = v.stall;
    D_cmp_sig = v.cmp;
    D_npc_op  = v.op;
    D_rs_val  = v.rs;
    e.id = id; e.fpc = v.fpc; e.dpc = v.dpc; e.di = v.di;
    e.link = v.dpc + LINK_OFS; e.v = v.v; e.err = v.err;
    sb.push_back(e);
    if (v.rst) begin
      // Checked before any clock edge, so the reset must act asynchronously.
      reset_n = 1'b0;
      #1;
      compare_out();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
    end else begin
      @(posedge clk);
      #1;
      compare_out();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Sequential fetch after reset.
    tbl.push_back(rst_vec());
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h3004, 32'h3000, imem(32'h3000), 1, 0));
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h3008, 32'h3004, imem(32'h3004), 1, 0));
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h300C, 32'h3008, imem(32'h3008), 1, 0));
    // Taken beq at 0x3004: target 0x3014.
    tbl.push_back(rst_vec());
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h3004, 32'h3000, imem(32'h3000), 1, 0));
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h3008, 32'h3004, 32'h1000_0003, 1, 0));
    tbl.push_back(mk(0, 0, 1, 2'd1, 0, 32'h3014, 32'h3008, DS ? imem(32'h3008) : 32'h0, DS, 0));
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h3018, 32'h3014, imem(32'h3014), 1, 0));
    // Not-taken beq: sequential, no flush.
    tbl.push_back(rst_vec());
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h3004, 32'h3000, imem(32'h3000), 1, 0));
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h3008, 32'h3004, 32'h1000_0003, 1, 0));
    tbl.push_back(mk(0, 0, 0, 2'd1, 0, 32'h300C, 32'h3008, imem(32'h3008), 1, 0));
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h3010, 32'h300C, imem(32'h300C), 1, 0));
    // Redirect ignored while D holds the reset bubble; then jal at 0x3000 -> 0x3040.
    tbl.push_back(rst_vec());
    tbl.push_back(mk(0, 0, 1, 2'd3, 32'h5000, 32'h3004, 32'h3000, 32'h0C00_0C10, 1, 0));
    tbl.push_back(mk(0, 0, 0, 2'd2, 0, 32'h3040, 32'h3004, DS ? imem(32'h3004) : 32'h0, DS, 0));
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h3044, 32'h3040, imem(32'h3040), 1, 0));
    // jr to misaligned, out-of-range, last-word and below-base addresses.
    tbl.push_back(rst_vec());
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h3004, 32'h3000, imem(32'h3000), 1, 0));
    tbl.push_back(mk(0, 0, 0, 2'd3, 32'h3001, 32'h3001, 32'h3004, DS ? imem(32'h3004) : 32'h0, DS, 1));
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h3005, 32'h3001, 32'h0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 2'd3, 32'h7000, 32'h7000, 32'h3005, 32'h0, DS, 1));
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h7004, 32'h7000, 32'h0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 2'd3, 32'h6FFC, 32'h6FFC, 32'h7004, 32'h0, DS, 0));
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h7000, 32'h6FFC, imem(32'h6FFC), 1, 1));
    tbl.push_back(mk(0, 0, 0, 2'd3, 32'h2FFC, 32'h2FFC, 32'h7000, 32'h0, DS, 1));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Stall across a taken branch defers the redirect; reset then drops a pending jump.
    run_vec(rst_vec(), 100);
    run_vec(mk(0, 0, 0, 2'd0, 0, 32'h3004, 32'h3000, imem(32'h3000), 1, 0), 101);
    run_vec(mk(0, 0, 0, 2'd0, 0, 32'h3008, 32'h3004, 32'h1000_0003, 1, 0), 102);
    run_vec(mk(0, 1, 1, 2'd1, 0, 32'h3008, 32'h3004, 32'h1000_0003, 1, 0), 103);
    run_vec(mk(0, 1, 1, 2'd1, 0, 32'h3008, 32'h3004, 32'h1000_0003, 1, 0), 104);
    run_vec(mk(0, 0, 1, 2'd1, 0, 32'h3014, 32'h3008, DS ? imem(32'h3008) : 32'h0, DS, 0), 105);
    run_vec(mk(0, 0, 0, 2'd0, 0, 32'h3018, 32'h3014, imem(32'h3014), 1, 0), 106);
    run_vec(mk(0, 1, 0, 2'd2, 0, 32'h3018, 32'h3014, imem(32'h3014), 1, 0), 107);
    run_vec(rst_vec(), 108);
    run_vec(mk(0, 0, 0, 2'd0, 0, 32'h3004, 32'h3000, imem(32'h3000), 1, 0), 109);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
